// File: rtl/paralelo_serial_if.sv
// Byte input handshake into the serializer: the producer drives data/valid, and the
// serializer returns ready.
interface paralelo_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial.sv
// Transmit serializer: bytes are queued in a small FIFO and shifted out MSB first,
// one bit per clk_32f. A comma preamble is sent first, and idle bytes fill empty slots.
module paralelo_serial #(
  parameter logic [7:0] IDLE_BYTE  = 8'hBC,
  parameter int         SYNC_BYTES = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  paralelo_serial_if.slave              s_in,
  output logic                          data_out,
  output logic                          byte_start,
  output logic                          valid_byte,
  output logic                          active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [0:0] ST_PREAMBLE = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_sh;
  logic [3:0]    r_pre_cnt;
  logic [0:0]    r_state;
  logic          r_valid_byte;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_load;
  logic w_may_pop;
  logic w_push;
  logic w_pop;

  assign s_in.ready_out = (r_count != FULL_CNT);
  assign w_push    = s_in.valid_in && s_in.ready_out;
  assign w_load    = (r_bit_cnt == 3'd7);
  // The last preamble boundary may already carry data, so it counts as a pop slot.
  assign w_may_pop = (r_state == ST_RUN) || (r_pre_cnt == 4'd0);
  assign w_pop     = w_load && w_may_pop && (r_count != '0);

  assign data_out   = r_sh[7];
  assign byte_start = (r_bit_cnt == 3'd0);
  assign valid_byte = r_valid_byte;
  assign active     = (r_state == ST_RUN);
  assign fifo_count = r_count;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt    <= 3'd0;
      r_sh         <= IDLE_BYTE;
      r_pre_cnt    <= 4'(SYNC_BYTES - 1);
      r_state      <= ST_PREAMBLE;
      r_valid_byte <= 1'b0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (!w_load) begin
        r_sh <= {r_sh[6:0], 1'b0};
      end else if (w_pop) begin
        r_sh         <= r_mem[r_rd_ptr];
        r_valid_byte <= 1'b1;
      end else begin
        r_sh         <= IDLE_BYTE;
        r_valid_byte <= 1'b0;
      end
      if (w_load && r_state == ST_PREAMBLE) begin
        if (r_pre_cnt != 4'd0) begin
          r_pre_cnt <= r_pre_cnt - 4'd1;
        end else begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  // Storage is not cleared on reset; only the pointers and the count are.
  always_ff @(posedge clk_32f) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_in.data_in;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
